// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle left shifter with valid/ready request and result handshakes.
// Ports:
//   clk, reset              - clock and synchronous active-high reset
//   start_valid/start_ready - request handshake; in_a and shift are sampled on the accept edge
//   in_a [N-1:0]            - operand
//   shift [SHW-1:0]         - shift amount
//   rotate                  - rotate instead of shift (only when SHIFT_SEQ_ROTATE_EN is defined)
//   busy                    - request in flight (RUN or DONE)
//   done_valid/done_ready   - result handshake
//   out [N-1:0], cout       - result and last bit shifted past the MSB
// Optional feature: define SHIFT_SEQ_ROTATE_EN to add the rotate input.
module shift_sequencer #(
    parameter int N        = 8,
    parameter int SHW      = 4,
    parameter int MAX_STEP = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start_valid,
    output logic           start_ready,
    input  logic [N-1:0]   in_a,
    input  logic [SHW-1:0] shift,
`ifdef SHIFT_SEQ_ROTATE_EN
    input  logic           rotate,
`endif
    output logic           busy,
    output logic           done_valid,
    input  logic           done_ready,
    output logic [N-1:0]   out,
    output logic           cout
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   acc_q, acc_d;
    logic [SHW-1:0] rem_q, rem_d;
    logic           cout_q, cout_d;
    logic [SHW-1:0] step;
    logic [IW-1:0]  idx;
    logic [N-1:0]   shifted;
`ifdef SHIFT_SEQ_ROTATE_EN
    logic           rot_q, rot_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
            rot_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            cout_q  <= cout_d;
`ifdef SHIFT_SEQ_ROTATE_EN
            rot_q   <= rot_d;
`endif
        end
    end

    always_comb begin
        step = (int'(rem_q) < MAX_STEP) ? rem_q : SHW'(MAX_STEP);
        // Last bit to cross the MSB this step; same position for shift and rotate.
        idx  = IW'(N - int'(step));
`ifdef SHIFT_SEQ_ROTATE_EN
        shifted = rot_q ? ((acc_q << step) | (acc_q >> (N - int'(step)))) : (acc_q << step);
`else
        shifted = acc_q << step;
`endif
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        cout_d  = cout_q;
`ifdef SHIFT_SEQ_ROTATE_EN
        rot_d   = rot_q;
`endif
        case (state_q)
            IDLE: if (start_valid) begin
                acc_d   = in_a;
                rem_d   = shift;
                cout_d  = 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
                rot_d   = rotate;
`endif
                state_d = (shift == '0) ? DONE : RUN;
            end
            RUN: begin
                cout_d  = acc_q[idx];
                acc_d   = shifted;
                rem_d   = rem_q - step;
                state_d = (rem_q == step) ? DONE : RUN;
            end
            DONE:    state_d = done_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign done_valid  = (state_q == DONE);
    assign out         = acc_q;
    assign cout        = cout_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: vector table, hand sequences and random requests against a spec-level model.
module tb_shift_sequencer;
    localparam int N        = 8;
    localparam int SHW      = 4;
    localparam int MAX_STEP = 3;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start_valid = 1'b0;
    logic           start_ready;
    logic [N-1:0]   in_a = '0;
    logic [SHW-1:0] shift = '0;
    logic           rotate = 1'b0;
    logic           busy;
    logic           done_valid;
    logic           done_ready = 1'b0;
    logic [N-1:0]   out;
    logic           cout;

    int checks = 0;
    int failures = 0;

    shift_sequencer #(.N(N), .SHW(SHW), .MAX_STEP(MAX_STEP)) dut (
        .clk(clk),
        .reset(reset),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .in_a(in_a),
        .shift(shift),
`ifdef SHIFT_SEQ_ROTATE_EN
        .rotate(rotate),
`endif
        .busy(busy),
        .done_valid(done_valid),
        .done_ready(done_ready),
        .out(out),
        .cout(cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]   a;
        logic [SHW-1:0] sh;
        logic [N-1:0]   eout;
        logic           ecout;
        int             elat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: result of one whole shift/rotate plus the expected latency in edges.
    task automatic model(input logic [N-1:0] a, input int sh, input logic rot,
                         output logic [N-1:0] eo, output logic ec, output int el);
        logic [2*N-1:0] dbl;
        int r;
        el = (sh + MAX_STEP - 1) / MAX_STEP;
        if (rot) begin
            r   = sh % N;
            dbl = {a, a} << r;
            eo  = dbl[2*N-1:N];
            ec  = (sh == 0) ? 1'b0 : a[(N - r) % N];
        end else begin
            eo = (sh >= N) ? '0 : N'(a << sh);
            ec = (sh >= 1 && sh <= N) ? a[N - sh] : 1'b0;
        end
    endtask

    task automatic run_req(input logic [N-1:0] a, input logic [SHW-1:0] sh, input logic rot,
                           output logic [N-1:0] o, output logic c, output int lat);
        @(negedge clk);
        start_valid = 1'b1;
        in_a = a;
        shift = sh;
        rotate = rot;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        lat = 0;
        while (!done_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        o = out;
        c = cout;
    endtask

    task automatic finish_req();
        @(negedge clk);
        done_ready = 1'b1;
        @(posedge clk);
        #1;
        done_ready = 1'b0;
        chk("ready_after_done", start_ready, 1);
        chk("valid_after_done", done_valid, 0);
    endtask

    task automatic do_vec(input string name, input logic [N-1:0] a, input logic [SHW-1:0] sh,
                          input logic rot, input logic [N-1:0] eo, input logic ec, input int el);
        logic [N-1:0] o;
        logic c;
        int lat;
        run_req(a, sh, rot, o, c, lat);
        chk({name, "_out"}, o, eo);
        chk({name, "_cout"}, c, ec);
        chk({name, "_lat"}, lat, el);
        finish_req();
    endtask

    initial begin
        vec_t vt[$];
        logic [N-1:0] o, eo, hold_o;
        logic c, ec, hold_c, rot;
        int lat, el;
        logic [N-1:0] ra;
        logic [SHW-1:0] rs;

        vt.push_back('{8'hF0, 4'd1, 8'hE0, 1'b1, 1});
        vt.push_back('{8'hF0, 4'd3, 8'h80, 1'b1, 1});
        vt.push_back('{8'hF0, 4'd6, 8'h00, 1'b0, 2});
        vt.push_back('{8'hA5, 4'd0, 8'hA5, 1'b0, 0});
        vt.push_back('{8'hFF, 4'd9, 8'h00, 1'b0, 3});
        vt.push_back('{8'h01, 4'd8, 8'h00, 1'b1, 3});
        vt.push_back('{8'h81, 4'd7, 8'h80, 1'b0, 3});
        vt.push_back('{8'hFF, 4'd15, 8'h00, 1'b0, 5});
        vt.push_back('{8'h5A, 4'd2, 8'h68, 1'b1, 1});

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_ready", start_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_valid", done_valid, 0);
        chk("rst_out", out, 0);
        chk("rst_cout", cout, 0);

        foreach (vt[i]) do_vec($sformatf("vec%0d", i), vt[i].a, vt[i].sh, 1'b0, vt[i].eout, vt[i].ecout, vt[i].elat);

        // Reset in the middle of a long request.
        @(negedge clk);
        start_valid = 1'b1;
        in_a = 8'hFF;
        shift = 4'd15;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        repeat (2) @(posedge clk);
        chk("midrun_busy", busy, 1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midrst_ready", start_ready, 1);
        chk("midrst_valid", done_valid, 0);
        chk("midrst_out", out, 0);
        chk("midrst_cout", cout, 0);

        // Backpressure: result held, new requests refused.
        run_req(8'h3C, 4'd4, 1'b0, o, c, lat);
        chk("bp_out", o, 8'hC0);
        chk("bp_cout", c, 1);
        chk("bp_lat", lat, 2);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            start_valid = (k == 2);
            in_a = 8'h11;
            shift = 4'd0;
            @(posedge clk);
            #1;
            chk("bp_hold_out", out, 8'hC0);
            chk("bp_hold_cout", cout, 1);
            chk("bp_hold_ready", start_ready, 0);
            chk("bp_hold_valid", done_valid, 1);
        end
        start_valid = 1'b0;
        finish_req();
        chk("bp_not_taken", out, 8'hC0);

        // done_ready with nothing pending leaves the block idle.
        @(negedge clk);
        done_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        done_ready = 1'b0;
        chk("idle_dr_ready", start_ready, 1);
        chk("idle_dr_valid", done_valid, 0);
        chk("idle_dr_out", out, 8'hC0);

`ifdef SHIFT_SEQ_ROTATE_EN
        do_vec("rot3", 8'h96, 4'd3, 1'b1, 8'hB4, 1'b0, 1);
        do_vec("rot11", 8'h96, 4'd11, 1'b1, 8'hB4, 1'b0, 4);
        do_vec("rot8", 8'h96, 4'd8, 1'b1, 8'h96, 1'b0, 3);
`endif

        for (int k = 0; k < 40; k++) begin
            ra = N'($urandom);
            rs = SHW'($urandom_range(0, 15));
`ifdef SHIFT_SEQ_ROTATE_EN
            rot = 1'($urandom);
`else
            rot = 1'b0;
`endif
            model(ra, int'(rs), rot, eo, ec, el);
            run_req(ra, rs, rot, o, c, lat);
            chk("rnd_out", o, eo);
            chk("rnd_cout", c, ec);
            chk("rnd_lat", lat, el);
            hold_o = o;
            hold_c = c;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            chk("rnd_stable", {out, cout}, {hold_o, hold_c});
            finish_req();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle controller for the ALU left-shift datapath.
- Accepts one shift request (operand plus amount) over a valid/ready handshake.
- Walks the request through a per-cycle shift stage that moves at most MAX_STEP bit positions per clock, tracking the carry-out bit along the way.
- Holds the result (out, cout) until the consumer takes it; sits between ALU issue logic and writeback.

Parameters:
- N, 8, operand/result width in bits.
- SHW, 4, width of the shift-amount field.
- MAX_STEP, 3, maximum bit positions shifted per cycle (1 <= MAX_STEP <= N).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start_valid  input  1  request present on in_a/shift.
- start_ready  output  1  block can accept a request (high only in IDLE).
- in_a  input  N  operand; sampled on the accept edge only.
- shift  input  SHW  shift amount; sampled on the accept edge only.
- busy  output  1  high in RUN or DONE.
- done_valid  output  1  result valid (high only in DONE).
- done_ready  input  1  consumer accepts the result.
- out  output  N  shifted result; registered, stable while done_valid is high.
- cout  output  1  last bit shifted out of the MSB; 0 if shift = 0.

Behaviour:
- Reset: state = IDLE, out = 0, cout = 0, remaining-count = 0, start_ready = 1, busy = 0, done_valid = 0. Reset overrides everything, including mid-RUN or DONE; any in-flight request is dropped.
- States: IDLE, RUN, DONE.
- IDLE: accept when start_valid && start_ready.
  - Load acc = in_a, rem = shift, cout = 0.
  - Next state is RUN, or DONE if shift = 0.
- RUN, each edge:
  - step = min(rem, MAX_STEP).
  - cout <= acc[N-step] (bit index of acc before the shift; zero-filled bits are legitimate 0).
  - acc <= acc << step, zero fill; rem <= rem - step.
  - If rem - step == 0, go to DONE.
  - start_valid is ignored in RUN.
- DONE:
  - done_valid = 1; out = acc; cout is held.
  - On done_ready, go to IDLE. done_valid drops on the following cycle.
  - No back-to-back accept in the same cycle as the done handshake.
- Latency: done_valid rises ceil(shift/MAX_STEP) edges after the accept edge (0 edges when shift = 0, i.e. the cycle right after accept).
- Arithmetic result equals the combinational left shifter:
  - out = (in_a << shift) truncated to N bits.
  - cout = in_a[N-shift] for 1 <= shift <= N, else 0.
  - shift > N yields out = 0, cout = 0. The block still iterates the full count; no early exit.
- out and cout do not change outside RUN except at accept (cout cleared; out is internal acc, visible only as registered output).
- done_ready held high with no result pending has no effect.

Optional Feature:
- Macro SHIFT_SEQ_ROTATE_EN.
- When defined:
  - Adds input rotate (1 bit), sampled at accept.
  - If rotate = 1, each step does a left rotate: bits leaving the MSB re-enter at the LSB.
  - cout = last bit that passed the MSB, i.e. in_a[(N - (shift mod N)) mod N] for shift > 0, else 0.
  - Amounts >= N wrap modulo N; iteration count is unchanged.
  - rotate = 0 behaves exactly as the base block.
- When undefined: no rotate port; logical shift only.

Test Plan:
- Reset mid-RUN: accept in_a=8'hFF, shift=15; assert reset after 2 edges -> next cycle state IDLE, start_ready=1, done_valid=0, out=0, cout=0.
- in_a=8'b11110000, shift=1 -> done_valid after 1 edge, out=8'b11100000, cout=1.
- in_a=8'b11110000, shift=3 -> 1 edge, out=8'b10000000, cout=1. Then shift=6 -> 2 edges, out=8'b00000000, cout=0.
- shift=0, in_a=8'hA5 -> done_valid the cycle after accept, out=8'hA5, cout=0. shift=9, in_a=8'hFF -> 3 edges, out=0, cout=0.
- Backpressure: shift=4 result with done_ready low for 5 cycles -> out/cout stable, start_ready=0; a start_valid pulse in that window is not accepted. Raise done_ready -> IDLE next edge.
- With SHIFT_SEQ_ROTATE_EN: in_a=8'b10010110, shift=3, rotate=1 -> out=8'b10110100, cout=0. Same with shift=11 -> identical out, 4 edges latency.
